// File: rtl/tetris_cmd_sched.sv
// rtl/tetris_cmd_sched.sv - arbitrates key pulses, gravity and garbage bars into one
// core command per WAIT state, and drives the bar mask the core samples in BAR.
package enum_type;
  typedef enum logic [3:0] {
    NONE, INIT, GEN, WAIT, BAR, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, LEFT, RIGHT, END
  } state_type;
endpackage

module tetris_cmd_sched
  import enum_type::*;
#(
  parameter logic [31:0] GRAV_BASE = 32'd50_000_000,
  parameter logic [31:0] GRAV_STEP = 32'd4_000_000,
  parameter logic [31:0] GRAV_MIN  = 32'd5_000_000,
  parameter logic [3:0]  MAX_LEVEL = 4'd9,
  parameter int          BAR_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot,
  input  logic        btn_rot_rev,
  input  logic        btn_down,
  input  logic        btn_drop,
  input  logic        btn_hold,
  input  logic        pause,
  input  logic        bar_valid,
  input  logic [9:0]  bar_mask_in,
  output logic        bar_ready,
  input  state_type   state,
  input  logic [15:0] score,
  output state_type   ctrl,
  output logic [9:0]  bar_mask,
  output logic [3:0]  level
);
  localparam int KEYS  = 7;
  localparam int PTR_W = $clog2(BAR_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BAR_DEPTH);

  state_type        ctrl_q, ctrl_d;
  logic [KEYS-1:0]  key_pend_q, key_pend_d, keys, key_req, key_sel, key_clr;
  logic             grav_pend_q, grav_pend_d, grav_clr, grav_run, grav_wrap;
  logic [31:0]      grav_cnt_q, grav_cnt_d, step_total, period;
  logic [3:0]       level_q, level_d;
  logic             in_menu, can_issue, manual_reload;
  logic [9:0]       mem_q [BAR_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             fifo_empty, push, pop;
  logic             score_unused;

  // Key index order is the arbitration order among keys (index 0 wins).
  function automatic state_type key_cmd(input int idx);
    case (idx)
      0:       key_cmd = DROP;
      1:       key_cmd = HOLD;
      2:       key_cmd = ROTATE;
      3:       key_cmd = ROTATE_REV;
      4:       key_cmd = LEFT;
      5:       key_cmd = RIGHT;
      default: key_cmd = DOWN;
    endcase
  endfunction

  assign keys         = {btn_down, btn_right, btn_left, btn_rot_rev, btn_rot, btn_hold, btn_drop};
  assign score_unused = ^score[3:0];
  assign fifo_empty   = (cnt_q == '0);
  assign bar_ready    = (cnt_q != FULL_CNT);
  assign push         = bar_valid && bar_ready && (state != INIT);
  assign pop          = (state == BAR) && !fifo_empty;
  assign bar_mask     = fifo_empty ? 10'd0 : mem_q[rd_ptr_q];
  assign ctrl         = ctrl_q;
  assign level        = level_q;

  always_comb begin
    in_menu   = (state == INIT) || (state == END);
    can_issue = (ctrl_q == NONE) && (in_menu || ((state == WAIT) && !pause));
    key_req   = in_menu ? keys : (key_pend_q | keys);
    key_sel   = key_req & (~key_req + 7'd1);
    ctrl_d    = NONE;
    key_clr   = '0;
    grav_clr  = 1'b0;
    if (can_issue) begin
      if (!in_menu && grav_pend_q) begin
        ctrl_d     = DOWN;
        grav_clr   = 1'b1;
        key_clr[6] = 1'b1;
      end else if (!in_menu && !fifo_empty) begin
        ctrl_d = BAR;
      end else if (key_req != '0) begin
        key_clr = key_sel;
        for (int i = 0; i < KEYS; i++)
          if (key_sel[i]) ctrl_d = key_cmd(i);
      end
    end
    // A pulse consumed by its own issue is gone; one landing on an already pending bit re-arms it.
    key_pend_d = in_menu ? '0 : ((key_pend_q & ~key_clr) | (keys & ~(key_clr & ~key_pend_q)));

    step_total = {28'd0, level_q} * GRAV_STEP;
    period     = ((GRAV_BASE > step_total) && ((GRAV_BASE - step_total) > GRAV_MIN)) ?
                 (GRAV_BASE - step_total) : GRAV_MIN;
    grav_run    = !in_menu && !pause;
    grav_wrap   = grav_run && (grav_cnt_q == period - 32'd1);
    grav_pend_d = in_menu ? 1'b0 : ((grav_pend_q & ~grav_clr) | grav_wrap);
    // Gravity's own DOWN already restarted the period at the wrap; only player moves reload it.
    manual_reload = (ctrl_d == DROP) || ((ctrl_d == DOWN) && !grav_clr);
    if ((state == GEN) || manual_reload || grav_wrap) grav_cnt_d = 32'd0;
    else if (grav_run)                                grav_cnt_d = grav_cnt_q + 32'd1;
    else                                              grav_cnt_d = grav_cnt_q;

    level_d = ((score[15:8] != 8'd0) || (score[7:4] > MAX_LEVEL)) ? MAX_LEVEL : score[7:4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= NONE;
      key_pend_q  <= '0;
      grav_pend_q <= 1'b0;
      grav_cnt_q  <= 32'd0;
      level_q     <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      key_pend_q  <= key_pend_d;
      grav_pend_q <= grav_pend_d;
      grav_cnt_q  <= grav_cnt_d;
      level_q     <= level_d;
      if (state == INIT) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bar_mask_in;
  end
endmodule

// File: tb/tb_tetris_cmd_sched.sv
// tb/tb_tetris_cmd_sched.sv - scoreboard bench for tetris_cmd_sched with directed vectors.
module tb_tetris_cmd_sched;
  import enum_type::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_left, btn_right, btn_rot, btn_rot_rev, btn_down, btn_drop, btn_hold;
  logic        pause, bar_valid;
  logic [9:0]  bar_mask_in;
  logic        bar_ready;
  state_type   state;
  logic [15:0] score;
  state_type   ctrl;
  logic [9:0]  bar_mask;
  logic [3:0]  level;

  typedef struct {
    int        cyc;
    state_type cmd;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  tetris_cmd_sched #(
    .GRAV_BASE(32'd20), .GRAV_STEP(32'd4), .GRAV_MIN(32'd2), .MAX_LEVEL(4'd9), .BAR_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_rot_rev(btn_rot_rev),
    .btn_down(btn_down), .btn_drop(btn_drop), .btn_hold(btn_hold),
    .pause(pause), .bar_valid(bar_valid), .bar_mask_in(bar_mask_in), .bar_ready(bar_ready),
    .state(state), .score(score), .ctrl(ctrl), .bar_mask(bar_mask), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_cmd(input state_type cmd, input int at);
    exp_t e;
    e.cyc = at;
    e.cmd = cmd;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    state = GEN;
    pause = 1'b0;
    tick(2);
  endtask

  // Scoreboard monitor: every non-NONE ctrl must match the head expectation in command and cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ctrl != NONE) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ctrl_unexpected: got %s expected NONE (cycle %0d)", ctrl.name(), cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cmd != ctrl || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL ctrl_issue: got %s at cycle %0d expected %s at cycle %0d",
                     ctrl.name(), cyc, e.cmd.name(), e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL ctrl_missing: got NONE at cycle %0d expected %s at cycle %0d",
                 cyc, e.cmd.name(), e.cyc);
      end
    end
  end

  logic [9:0] masks [5] = '{10'h3FE, 10'h1FF, 10'h2FF, 10'h37F, 10'h3BF};

  initial begin
    int c;
    reset_n = 1'b0;
    {btn_left, btn_right, btn_rot, btn_rot_rev, btn_down, btn_drop, btn_hold} = '0;
    pause = 1'b0; bar_valid = 1'b0; bar_mask_in = '0; state = GEN; score = 16'h0000;
    tick(2);
    check("rst_ctrl", 32'(ctrl), 32'(NONE));
    check("rst_bar_ready", 32'(bar_ready), 32'd1);
    check("rst_bar_mask", 32'(bar_mask), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    tick(1);
    reset_n = 1'b1;

    // Single key: pulse at cycle 10, LEFT at 11 only
    while (cyc < 10) tick(1);
    state = WAIT; btn_left = 1'b1;
    expect_cmd(LEFT, 11);
    tick(1);
    btn_left = 1'b0;
    tick(2);
    idle();

    // DROP beats LEFT; LEFT follows once the core returns to WAIT
    c = cyc;
    state = WAIT; btn_drop = 1'b1; btn_left = 1'b1;
    expect_cmd(DROP, c + 1);
    tick(1);
    btn_drop = 1'b0; btn_left = 1'b0; state = DROP;
    tick(3);
    state = WAIT;
    expect_cmd(LEFT, c + 5);
    tick(3);
    idle();

    // Pause holds the pending ROTATE until released
    c = cyc;
    state = WAIT; pause = 1'b1; btn_rot = 1'b1;
    tick(1);
    btn_rot = 1'b0;
    tick(1);
    pause = 1'b0;
    expect_cmd(ROTATE, c + 3);
    tick(3);
    idle();

    // Bar FIFO fill: fifth push sees bar_ready low
    for (int i = 0; i < 5; i++) begin
      bar_valid = 1'b1; bar_mask_in = masks[i];
      check($sformatf("bar_ready_push%0d", i), 32'(bar_ready), (i < 4) ? 32'd1 : 32'd0);
      tick(1);
    end
    bar_valid = 1'b0;
    check("bar_head_full", 32'(bar_mask), 32'h3FE);
    for (int i = 0; i < 4; i++) begin
      state = WAIT;
      expect_cmd(BAR, cyc + 1);
      tick(1);
      state = BAR;
      check($sformatf("bar_mask_pop%0d", i), 32'(bar_mask), 32'(masks[i]));
      tick(1);
    end
    state = WAIT;
    tick(2);
    check("bar_mask_empty", 32'(bar_mask), 32'd0);
    check("bar_ready_empty", 32'(bar_ready), 32'd1);
    idle();

    // END: a key pulse restarts; pending requests are discarded
    c = cyc;
    state = WAIT; pause = 1'b1; btn_right = 1'b1;
    tick(1);
    btn_right = 1'b0; state = END; btn_hold = 1'b1;
    expect_cmd(HOLD, c + 2);
    tick(1);
    btn_hold = 1'b0;
    tick(1);
    state = WAIT; pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("end_cleared%0d", i), 32'(ctrl), 32'(NONE));
    end
    idle();

    // Gravity at level 0: DOWN every 20 cycles
    check("level_0", 32'(level), 32'd0);
    c = cyc;
    state = WAIT;
    expect_cmd(DOWN, c + 21);
    expect_cmd(DOWN, c + 41);
    expect_cmd(DOWN, c + 61);
    tick(62);
    idle();

    // Gravity at level 3: period 20 - 3*4 = 8
    score = 16'h0030;
    tick(1);
    idle();
    check("level_3", 32'(level), 32'd3);
    c = cyc;
    state = WAIT;
    expect_cmd(DOWN, c + 9);
    expect_cmd(DOWN, c + 17);
    expect_cmd(DOWN, c + 25);
    tick(26);
    idle();

    // Level saturation
    score = 16'h0090; tick(1); idle();
    check("level_90", 32'(level), 32'd9);
    score = 16'h0100; tick(1); idle();
    check("level_100", 32'(level), 32'd9);
    score = 16'h0000; tick(1); idle();
    check("level_back0", 32'(level), 32'd0);

    // Reset asserted while the core is in BAR empties the FIFO at once
    for (int i = 0; i < 2; i++) begin
      bar_valid = 1'b1; bar_mask_in = masks[i];
      tick(1);
    end
    bar_valid = 1'b0;
    state = WAIT;
    expect_cmd(BAR, cyc + 1);
    tick(1);
    state = BAR;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midbar_rst_mask", 32'(bar_mask), 32'd0);
    check("midbar_rst_ready", 32'(bar_ready), 32'd1);
    check("midbar_rst_ctrl", 32'(ctrl), 32'(NONE));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    state = WAIT;
    tick(3);
    idle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
